alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 140 ++++++++++++++
 tb/tb_alu_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared combinational ALU.
// Each accepted operation is sequenced IDLE -> EXEC -> RESP; the response is
// held until the consumer takes it, after which priority passes to the other
// requester.
module alu_arbiter #(
  parameter int PRIO_FIRST = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_out,
  input  logic        alu_zf,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        rsp_zf,
  output logic        rsp_err,
  output logic        busy,
  output logic [15:0] ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state, state_next;
  logic        prio;
  logic        grant_any, grant_id;
  logic        take, done;
  logic [31:0] lat_a, lat_b;
  logic [3:0]  lat_op;
  logic        lat_id;
  logic [31:0] res_data;
  logic        res_zf, res_err;
  logic [15:0] ops_cnt;
  logic        lat_legal;

  // Opcodes the shared ALU implements; anything else is reported as an error.
  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      4'd0, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10: return 1'b1;
      default:                                   return 1'b0;
    endcase
  endfunction

  assign lat_legal = op_legal(lat_op);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Grant selection, ready generation and next-state decode.
  always_comb begin
    state_next = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    take       = 1'b0;
    done       = 1'b0;
    grant_any  = req0_valid | req1_valid;
    grant_id   = (req0_valid && req1_valid) ? prio : req1_valid;
    case (state)
      IDLE: begin
        req0_ready = grant_any && !grant_id;
        req1_ready = grant_any && grant_id;
        if (grant_any) begin
          take       = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        if (rsp_ready) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand latch, result capture, priority rotation and completion counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio     <= (PRIO_FIRST != 0);
      lat_a    <= '0;
      lat_b    <= '0;
      lat_op   <= '0;
      lat_id   <= 1'b0;
      res_data <= '0;
      res_zf   <= 1'b0;
      res_err  <= 1'b0;
      ops_cnt  <= '0;
    end else begin
      if (take) begin
        lat_id <= grant_id;
        lat_a  <= grant_id ? req1_a  : req0_a;
        lat_b  <= grant_id ? req1_b  : req0_b;
        lat_op <= grant_id ? req1_op : req0_op;
      end
      if (state == EXEC) begin
        res_err  <= !lat_legal;
        res_data <= lat_legal ? alu_out : 32'd0;
        res_zf   <= lat_legal ? alu_zf  : 1'b0;
      end
      if (done) begin
        prio    <= ~lat_id;
        ops_cnt <= ops_cnt + 16'd1;
      end
    end
  end

  // ALU is only driven while executing; an illegal opcode is replaced by 0.
  assign alu_a  = (state == EXEC) ? lat_a : 32'd0;
  assign alu_b  = (state == EXEC) ? lat_b : 32'd0;
  assign alu_op = (state == EXEC && lat_legal) ? lat_op : 4'd0;

  // Response payload is visible only while a response is pending.
  assign rsp_valid = (state == RESP);
  assign rsp_id    = (state == RESP) ? lat_id   : 1'b0;
  assign rsp_data  = (state == RESP) ? res_data : 32'd0;
  assign rsp_zf    = (state == RESP) ? res_zf   : 1'b0;
  assign rsp_err   = (state == RESP) ? res_err  : 1'b0;

  assign busy     = (state != IDLE);
  assign ops_done = ops_cnt;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios followed by random
// traffic, all compared every cycle against a transaction-level model.
module tb_alu_arbiter;

  localparam int P = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_op;
  logic        alu_zf;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zf, rsp_err, busy;
  logic [31:0] rsp_data;
  logic [15:0] ops_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: at most one operation in flight; age counts cycles since acceptance.
  bit          pend;
  int          age;
  bit          p_id;
  logic [31:0] p_a, p_b;
  logic [3:0]  p_op;
  bit          m_prio;
  logic [15:0] m_ops;
  int          grant_log[$];
  int          rsp_cnt[2];

  alu_arbiter #(.PRIO_FIRST(P)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_zf(alu_zf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_zf(rsp_zf), .rsp_err(rsp_err),
    .busy(busy), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    case (op)
      4'd0:    return a + b;
      4'd2:    return a - b;
      4'd4:    return a & b;
      4'd5:    return a | b;
      4'd6:    return a ^ b;
      4'd7:    return ~(a | b);
      4'd10:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit legal(input logic [3:0] op);
    return op inside {4'd0, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10};
  endfunction

  // The shared combinational ALU the arbiter fronts.
  always_comb begin
    alu_out = alu_ref(alu_a, alu_b, alu_op);
    alu_zf  = (alu_out == 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_grant();
    return (req0_valid && req1_valid) ? m_prio : req1_valid;
  endfunction

  task automatic check_outputs();
    bit any, g, exec_c, resp_c, lg;
    logic [31:0] r;
    any    = req0_valid | req1_valid;
    g      = model_grant();
    exec_c = pend && age == 1;
    resp_c = pend && age == 2;
    lg     = legal(p_op);
    r      = alu_ref(p_a, p_b, p_op);
    chk("req0_ready", req0_ready, !pend && any && !g);
    chk("req1_ready", req1_ready, !pend && any && g);
    chk("busy", busy, pend);
    chk("alu_a", alu_a, exec_c ? p_a : 32'd0);
    chk("alu_b", alu_b, exec_c ? p_b : 32'd0);
    chk("alu_op", alu_op, (exec_c && lg) ? p_op : 4'd0);
    chk("rsp_valid", rsp_valid, resp_c);
    chk("rsp_id", rsp_id, resp_c ? p_id : 1'b0);
    chk("rsp_data", rsp_data, (resp_c && lg) ? r : 32'd0);
    chk("rsp_zf", rsp_zf, resp_c && lg && r == 32'd0);
    chk("rsp_err", rsp_err, resp_c && !lg);
    chk("ops_done", ops_done, m_ops);
    if (!rst && req0_valid && req0_ready) grant_log.push_back(0);
    if (!rst && req1_valid && req1_ready) grant_log.push_back(1);
    if (!rst && rsp_valid && rsp_ready) rsp_cnt[rsp_id]++;
  endtask

  task automatic update_model();
    bit g;
    g = model_grant();
    if (rst) begin
      pend = 0; age = 0; m_prio = (P != 0); m_ops = 16'd0;
    end else if (!pend) begin
      if (req0_valid || req1_valid) begin
        pend = 1; age = 1; p_id = g;
        p_a  = g ? req1_a  : req0_a;
        p_b  = g ? req1_b  : req0_b;
        p_op = g ? req1_op : req0_op;
      end
    end else if (age == 1) begin
      age = 2;
    end else if (rsp_ready) begin
      pend = 0; m_ops = m_ops + 16'd1; m_prio = !p_id;
    end
  endtask

  task automatic step(input bit do_chk);
    @(negedge clk);
    if (do_chk) check_outputs();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic set_req(input int n, input bit v, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] op);
    if (n == 0) begin req0_valid = v; req0_a = a; req0_b = b; req0_op = op; end
    else        begin req1_valid = v; req1_a = a; req1_b = b; req1_op = op; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b1);
    step(1'b1);
    rst = 1'b0;
  endtask

  // Issue one operation from requester n and run it to completion.
  task automatic one_op(input int n, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op);
    set_req(n, 1'b1, a, b, op);
    rsp_ready = 1'b1;
    step(1'b1);
    set_req(n, 1'b0, 32'd0, 32'd0, 4'd0);
    step(1'b1);
  endtask

  logic [3:0] legal_ops [7] = '{4'd0, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10};

  initial begin
    int n;
    rst = 1'b1; rsp_ready = 1'b0;
    set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
    set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
    step(1'b0);
    do_reset();
    chk("reset_busy", busy, 1'b0);
    chk("reset_ops_done", ops_done, 16'd0);

    // Single add from requester 0, response two cycles after the transfer.
    one_op(0, 32'd12, 32'd12, 4'd0);
    chk("add_valid", rsp_valid, 1'b1);
    chk("add_id", rsp_id, 1'b0);
    chk("add_data", rsp_data, 32'd24);
    chk("add_zf", rsp_zf, 1'b0);
    step(1'b1);
    chk("add_ops_done", ops_done, 16'd1);

    // Subtractions: zero result and wrap-around.
    one_op(1, 32'd1, 32'd1, 4'd2);
    chk("sub1_data", rsp_data, 32'd0);
    chk("sub1_zf", rsp_zf, 1'b1);
    chk("sub1_id", rsp_id, 1'b1);
    step(1'b1);
    one_op(0, 32'd0, 32'd1, 4'd2);
    chk("sub0_data", rsp_data, 32'hFFFF_FFFF);
    chk("sub0_zf", rsp_zf, 1'b0);
    step(1'b1);

    // Both requesters valid continuously: grants alternate from reset priority.
    do_reset();
    grant_log.delete();
    rsp_cnt[0] = 0; rsp_cnt[1] = 0;
    set_req(0, 1'b1, 32'd5, 32'd3, 4'd6);
    set_req(1, 1'b1, 32'd9, 32'd9, 4'd4);
    rsp_ready = 1'b1;
    n = 0;
    while (rsp_cnt[0] + rsp_cnt[1] < 4 && n < 40) begin step(1'b1); n++; end
    set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
    set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
    chk("alt_budget", rsp_cnt[0] + rsp_cnt[1], 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("alt_grant%0d", i), (grant_log.size() > i) ? grant_log[i] : -1, i % 2);
    chk("alt_cnt0", rsp_cnt[0], 2);
    chk("alt_cnt1", rsp_cnt[1], 2);
    while (pend) step(1'b1);

    // Consumer back-pressure: payload held for three cycles, no new grants.
    set_req(1, 1'b1, 32'h8000_0000, 32'd1, 4'd5);
    rsp_ready = 1'b0;
    step(1'b1);
    set_req(0, 1'b1, 32'd1, 32'd2, 4'd0);
    step(1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", rsp_valid, 1'b1);
      chk("bp_data", rsp_data, 32'h8000_0001);
      chk("bp_ready0", req0_ready, 1'b0);
      chk("bp_ready1", req1_ready, 1'b0);
      step(1'b1);
    end
    n = ops_done;
    rsp_ready = 1'b1;
    set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
    set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
    step(1'b1);
    chk("bp_complete", ops_done, 16'(n + 1));

    // Illegal opcode and signed set-less-than.
    one_op(0, 32'd7, 32'd7, 4'd3);
    chk("ill_err", rsp_err, 1'b1);
    chk("ill_data", rsp_data, 32'd0);
    chk("ill_zf", rsp_zf, 1'b0);
    step(1'b1);
    one_op(1, 32'd0, 32'd1, 4'd10);
    chk("slt_data", rsp_data, 32'd1);
    chk("slt_err", rsp_err, 1'b0);
    step(1'b1);

    // Reset during EXEC discards the operation; a waiting req1 is granted next.
    do_reset();
    set_req(0, 1'b1, 32'd4, 32'd4, 4'd0);
    step(1'b1);
    set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
    set_req(1, 1'b1, 32'd2, 32'd3, 4'd0);
    rst = 1'b1;
    step(1'b1);
    rst = 1'b0;
    chk("rexec_valid", rsp_valid, 1'b0);
    chk("rexec_busy", busy, 1'b0);
    chk("rexec_ops", ops_done, 16'd0);
    chk("rexec_ready1", req1_ready, 1'b1);
    step(1'b1);
    set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
    step(1'b1);
    step(1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      for (int r = 0; r < 2; r++) begin
        logic [3:0]  op;
        logic [31:0] a, b;
        op = ($urandom_range(0, 7) == 0) ? 4'($urandom) : legal_ops[$urandom_range(0, 6)];
        a  = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
        b  = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
        set_req(r, ($urandom_range(0, 2) != 0), a, b, op);
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
      rst       = ($urandom_range(0, 49) == 0);
      step(1'b1);
    end
    rst = 1'b0;
    step(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
